// File: rtl/snake_move_ctrl.sv
// -----------------------------------------------------------------------------
// snake_move_ctrl
//
// Movement controller for a snake game on a 32x32 wrapping grid. It keeps the
// body as a shift register of (x,y) segments and turns button presses into a
// pending direction. The head advances one cell on each move strobe. The
// controller grows the body on request, and detects a self-collision, which
// ends the game.
//
// Parameters
//   MAX_LEN    maximum number of body segments, head included
//   START_LEN  body length after reset (1..MAX_LEN)
//   START_X    head x after reset (0..31)
//   START_Y    head y after reset (0..31)
//
// Ports
//   clk            single clock; all state changes on its rising edge
//   reset          synchronous, active-high reset
//   tick           one-cycle move strobe
//   btn[3:0]       direction requests {left,down,right,up}, level, debounced
//   grow           one-cycle request to lengthen the body at the next move
//   seg_idx[3:0]   segment read index (0 = head)
//   seg_x/seg_y    coordinates of segment seg_idx (combinational read, 0 when
//                  seg_idx >= length)
//   head_x/head_y  registered head coordinates
//   length         current body length
//   move_done      one-cycle pulse in the cycle the new positions are visible
//   game_over      high while the game is over
// -----------------------------------------------------------------------------
module snake_move_ctrl #(
    parameter int MAX_LEN   = 16,
    parameter int START_LEN = 3,
    parameter int START_X   = 16,
    parameter int START_Y   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] btn,
    input  logic       grow,
    input  logic [3:0] seg_idx,
    output logic [4:0] seg_x,
    output logic [4:0] seg_y,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    output logic       move_done,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OVER
    } state_t;

    // Direction codes; opposite directions differ only in bit 1.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    state_t     state_q, state_d;
    logic [1:0] dir_q;
    logic [1:0] pend_q, pend_d;
    logic       grow_pend_q;
    logic [4:0] len_q;
    logic       move_done_q;
    logic [4:0] sx_q [MAX_LEN];
    logic [4:0] sy_q [MAX_LEN];

    logic [1:0] req_dir;
    logic [4:0] nx, ny;
    logic       grow_eff;
    logic       hit;
    logic       move_try;
    logic       move_ok;
    int         lim;

    // ------------------------------------------------------------------
    // Direction request: priority up > right > down > left, and a request
    // that would reverse onto the neck is dropped.
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_dir = DIR_LEFT;
        if (btn[0])      req_dir = DIR_UP;
        else if (btn[1]) req_dir = DIR_RIGHT;
        else if (btn[2]) req_dir = DIR_DOWN;

        pend_d = pend_q;
        if ((|btn) && (req_dir != (dir_q ^ 2'b10)))
            pend_d = req_dir;
    end

    // ------------------------------------------------------------------
    // Candidate head and self-collision against the pre-move body. The
    // tail cell counts as free unless the body grows on this move.
    // ------------------------------------------------------------------
    always_comb begin
        nx = sx_q[0];
        ny = sy_q[0];
        case (pend_q)
            DIR_UP:    ny = sy_q[0] - 5'd1;
            DIR_RIGHT: nx = sx_q[0] + 5'd1;
            DIR_DOWN:  ny = sy_q[0] + 5'd1;
            default:   nx = sx_q[0] - 5'd1;
        endcase

        grow_eff = grow_pend_q | grow;
        lim      = grow_eff ? int'(len_q) : int'(len_q) - 1;

        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < lim && sx_q[i] == nx && sy_q[i] == ny)
                hit = 1'b1;
        end

        move_try = (state_q == S_RUN) && tick;
        move_ok  = move_try && !hit;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|btn) state_d = S_RUN;
            S_RUN:   if (move_try && hit) state_d = S_OVER;
            default: state_d = S_OVER;
        endcase
    end

    // FSM: outputs
    always_comb begin
        game_over = (state_q == S_OVER);
    end

    // ------------------------------------------------------------------
    // Body, direction, length and growth bookkeeping
    // ------------------------------------------------------------------
    // NOTE: the segment array is reset explicitly because the starting body
    // is architecturally visible through seg_x/seg_y right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < START_LEN) begin
                    sx_q[i] <= 5'(START_X - i);
                    sy_q[i] <= 5'(START_Y);
                end else begin
                    sx_q[i] <= 5'd0;
                    sy_q[i] <= 5'd0;
                end
            end
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            len_q       <= 5'(START_LEN);
            move_done_q <= 1'b0;
        end else begin
            move_done_q <= move_ok;

            // Inputs are frozen out once the game is over.
            if (state_q != S_OVER)
                pend_q <= pend_d;

            if (move_ok) begin
                dir_q <= pend_q;
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    sx_q[i] <= sx_q[i-1];
                    sy_q[i] <= sy_q[i-1];
                end
                sx_q[0]     <= nx;
                sy_q[0]     <= ny;
                grow_pend_q <= 1'b0;
                if (grow_eff && len_q < 5'(MAX_LEN))
                    len_q <= len_q + 5'd1;
            end else if (grow && state_q != S_OVER) begin
                grow_pend_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        seg_x = 5'd0;
        seg_y = 5'd0;
        if ({1'b0, seg_idx} < len_q && int'(seg_idx) < MAX_LEN) begin
            seg_x = sx_q[seg_idx];
            seg_y = sy_q[seg_idx];
        end
    end

    assign head_x    = sx_q[0];
    assign head_y    = sy_q[0];
    assign length    = len_q;
    assign move_done = move_done_q;

endmodule
